// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the 640x480 scanout / VRAM arbitration path.
//   - 800x525 raster timing limits (last index of line, frame, active area)
//   - 320x240 8 bpp framebuffer geometry (two pixels per 16-bit word)
//   - arbiter state enum
// ----------------------------------------------------------------------------
package display_pkg;

    localparam int H_LINE   = 799;   // last sx of a line
    localparam int V_SCREEN = 524;   // last sy of a frame
    localparam int HA_END   = 639;   // last active sx
    localparam int VA_END   = 479;   // last active sy

    localparam int FB_W          = 320;
    localparam int FB_H          = 240;
    localparam int WORDS_PER_ROW = 160;
    localparam int FB_WORDS      = 38400;

    typedef enum logic {
        SYNC = 1'b0,   // waiting for the first (0,0) of a frame
        RUN  = 1'b1    // locked to the raster, scan slots active
    } arb_state_t;

endpackage

// File: rtl/scan_addr_gen.sv
// ----------------------------------------------------------------------------
// scan_addr_gen
// Framebuffer row tracking and scan-slot address generation.
// Each framebuffer row is shown on two screen lines, so the row base advances
// by one row's worth of words after every odd active line and returns to 0 at
// the end of the frame.
//   clk_pix   : pixel clock
//   rst       : synchronous active-high reset
//   run       : arbiter is locked to the raster (RUN and not in reset)
//   de        : active-video flag
//   sx, sy    : raster counters
//   scan_slot : this cycle belongs to the scanout fetch
//   scan_addr : word address fetched in a scan slot
// ----------------------------------------------------------------------------
module scan_addr_gen
    import display_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              run,
    input  logic              de,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    output logic              scan_slot,
    output logic [ADDR_W-1:0] scan_addr
);

    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] row_base_d;

    // One fetch per four pixels: a word holds two pixels, each shown twice.
    assign scan_slot = run && de && (sx[1:0] == 2'b00);
    assign scan_addr = row_base_q + ADDR_W'(sx[9:2]);

    // Incremental row stepping only; no sy*160 product is ever formed.
    always_comb begin
        row_base_d = row_base_q;
        if (sx == 10'(H_LINE)) begin
            if (sy == 10'(V_SCREEN)) begin
                row_base_d = '0;
            end else if (sy[0] && (sy < 10'(VA_END))) begin
                row_base_d = row_base_q + ADDR_W'(WORDS_PER_ROW);
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments with the reset tested
    // inside the clocked block, so reset is sampled on clk_pix like any input.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            row_base_q <= '0;
        end else begin
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/vram_scan_arbiter.sv
// ----------------------------------------------------------------------------
// vram_scan_arbiter
// Shares a single-port VRAM between 2x-scaled 320x240 scanout and one client.
// Scanout owns every fourth active-video cycle; the client gets all others.
//   clk_pix, rst              : pixel clock, synchronous active-high reset
//   sx, sy, de                : raster position and active-video flag
//   mem_addr/we/wdata/rdata   : RAM port (read data one cycle after address)
//   cl_req/we/addr/wdata      : client request, held until cl_ack
//   cl_ack                    : client request issued to RAM this cycle
//   cl_rvalid, cl_rdata       : client read return, one cycle after the ack
//   pix_out, pix_de           : pixel index and active flag, 2 cycles after sx
// ----------------------------------------------------------------------------
module vram_scan_arbiter
    import display_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              de,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              cl_req,
    input  logic              cl_we,
    input  logic [ADDR_W-1:0] cl_addr,
    input  logic [DATA_W-1:0] cl_wdata,
    output logic              cl_ack,
    output logic              cl_rvalid,
    output logic [DATA_W-1:0] cl_rdata,
    output logic [7:0]        pix_out,
    output logic              pix_de
);

    arb_state_t        state_q, state_d;
    logic              run;
    logic              scan_slot;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] addr_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              slot_d1_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_src;
    logic              sx1_d1_q;
    logic              de_d1_q;
    logic [7:0]        pix_out_q, pix_out_d;
    logic              pix_de_q;

    // Combinational outputs are forced quiet while reset is asserted.
    assign run = (state_q == RUN) && !rst;

    scan_addr_gen #(.ADDR_W(ADDR_W)) u_scan_addr_gen (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .run       (run),
        .de        (de),
        .sx        (sx),
        .sy        (sy),
        .scan_slot (scan_slot),
        .scan_addr (scan_addr)
    );

    // FSM: locks onto the raster at the first (0,0) and never leaves RUN.
    // NOTE: every combinational output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC:    if ((sx == 10'd0) && (sy == 10'd0)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SYNC;
        endcase
    end

    // RAM port mux: scan slot wins, otherwise a pending client is granted.
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = cl_wdata;
        cl_ack    = 1'b0;
        if (rst) begin
            mem_addr = '0;
        end else if (scan_slot) begin
            mem_addr = scan_addr;
        end else if (cl_req) begin
            cl_ack   = 1'b1;
            mem_addr = cl_addr;
            mem_we   = cl_we;
        end
    end

    // The fetch for a 4-pixel group lands while its first pixel is in stage
    // two, so that pixel takes the RAM data directly; the rest use word_q.
    assign word_src  = slot_d1_q ? mem_rdata : word_q;
    assign pix_out_d = de_d1_q ? (sx1_d1_q ? word_src[8 +: 8] : word_src[0 +: 8])
                               : 8'h00;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q   <= SYNC;
            addr_q    <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            slot_d1_q <= 1'b0;
            word_q    <= '0;
            sx1_d1_q  <= 1'b0;
            de_d1_q   <= 1'b0;
            pix_out_q <= '0;
            pix_de_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= mem_addr;
            rvalid_q  <= cl_ack && !cl_we;
            if (rvalid_q) rdata_q <= mem_rdata;
            slot_d1_q <= scan_slot;
            if (slot_d1_q) word_q <= mem_rdata;
            sx1_d1_q  <= sx[1];
            de_d1_q   <= de && (state_q == RUN);
            pix_out_q <= pix_out_d;
            pix_de_q  <= de_d1_q;
        end
    end

    // Read data is presented in the valid cycle and then held by rdata_q.
    assign cl_rvalid = rvalid_q;
    assign cl_rdata  = rvalid_q ? mem_rdata : rdata_q;
    assign pix_out   = pix_out_q;
    assign pix_de    = pix_de_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_scan_arbiter
// Directed bench for vram_scan_arbiter with a synchronous-read RAM model.
// RAM word n holds n, except word 160 which holds 16'hBBAA. Lines that carry
// no directed checks are compressed to their end-of-line cycle (sx=799),
// which is the only cycle that advances the row base.
// ----------------------------------------------------------------------------
module tb_vram_scan_arbiter;

    logic        clk_pix = 1'b0;
    logic        rst;
    logic [9:0]  sx, sy;
    logic        de;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        cl_req, cl_we;
    logic [15:0] cl_addr, cl_wdata;
    logic        cl_ack, cl_rvalid;
    logic [15:0] cl_rdata;
    logic [7:0]  pix_out;
    logic        pix_de;

    always #5 clk_pix = ~clk_pix;

    vram_scan_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .sx        (sx),
        .sy        (sy),
        .de        (de),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cl_req    (cl_req),
        .cl_we     (cl_we),
        .cl_addr   (cl_addr),
        .cl_wdata  (cl_wdata),
        .cl_ack    (cl_ack),
        .cl_rvalid (cl_rvalid),
        .cl_rdata  (cl_rdata),
        .pix_out   (pix_out),
        .pix_de    (pix_de)
    );

    // RAM model: synchronous write, read data valid one cycle after address.
    logic [15:0] ram [0:65535];
    int          wr_cnt = 0;

    initial begin
        for (int n = 0; n < 65536; n++) ram[n] <= 16'(n);
        ram[160] <= 16'hBBAA;
    end

    always @(posedge clk_pix) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            if (mem_addr == 16'd20000) wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input int a);
        return (a == 160) ? 16'hBBAA : 16'(a);
    endfunction

    // Reference state: lock flag and the two-cycle pixel history.
    typedef struct packed {
        logic       de;
        logic       ok;
        logic [9:0] x;
        logic [9:0] y;
    } hist_t;

    hist_t h1 = '0, h2 = '0, cur;
    bit    exp_run = 0;
    bit    grp_ok  = 0;
    int    ack_cnt = 0;

    // Values applied to the DUT inputs at the start of the next step.
    logic        nx_rst = 1'b1, nx_req = 1'b0, nx_we = 1'b0;
    logic [15:0] nx_addr = '0, nx_wdata = '0;

    initial begin
        rst = 1'b1; sx = '0; sy = '0; de = 1'b0;
        cl_req = 1'b0; cl_we = 1'b0; cl_addr = '0; cl_wdata = '0;
    end

    task automatic step(input int x, input int y);
        bit          exp_slot;
        int          wa;
        logic [15:0] w;
        @(posedge clk_pix);
        #2;
        rst = nx_rst; cl_req = nx_req; cl_we = nx_we; cl_addr = nx_addr; cl_wdata = nx_wdata;
        sx = 10'(x); sy = 10'(y); de = (x < 640) && (y < 480);
        #2;
        exp_slot = exp_run && de && (x % 4 == 0) && !rst;
        if (rst) begin
            check("rst_ack", cl_ack, 0);
            check("rst_we", mem_we, 0);
            check("rst_addr", mem_addr, 0);
        end else if (exp_slot) begin
            check("slot_addr", mem_addr, 32'((y / 2) * 160 + x / 4));
            check("slot_we", mem_we, 0);
            check("slot_ack", cl_ack, 0);
        end else if (cl_req) begin
            check("grant_ack", cl_ack, 1);
            check("grant_addr", mem_addr, cl_addr);
            check("grant_we", mem_we, cl_we);
        end else begin
            check("idle_ack", cl_ack, 0);
            check("idle_we", mem_we, 0);
        end
        if (cl_ack) ack_cnt++;

        check("pix_de", pix_de, h2.de);
        if (!h2.de) begin
            check("pix_blank", pix_out, 0);
        end else if (h2.ok) begin
            wa = (int'(h2.y) / 2) * 160 + int'(h2.x) / 4;
            w  = exp_word(wa);
            check("pix_out", pix_out, h2.x[1] ? w[15:8] : w[7:0]);
        end

        if (rst) grp_ok = 0;
        else if (de && (x % 4 == 0)) grp_ok = exp_run;
        cur.de = de && exp_run && !rst;
        cur.ok = grp_ok;
        cur.x  = 10'(x);
        cur.y  = 10'(y);
        h2 = rst ? '0 : h1;
        h1 = rst ? '0 : cur;
        if (rst) exp_run = 0;
        else if (x == 0 && y == 0) exp_run = 1;
    endtask

    task automatic full_line(input int y);
        for (int x = 0; x < 800; x++) step(x, y);
    endtask

    task automatic short_lines(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) step(799, y);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, cl_ack, 0);
        check({tag, "_rvalid"}, cl_rvalid, 0);
        check({tag, "_rdata"}, cl_rdata, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_pix"}, pix_out, 0);
        check({tag, "_pixde"}, pix_de, 0);
    endtask

    initial begin
        // Power-up reset at (300,100) with a request pending: nothing granted.
        nx_rst = 1'b1; nx_req = 1'b1; nx_addr = 16'd5;
        step(300, 100);
        step(301, 100);
        check_all_zero("reset");
        nx_rst = 1'b0;

        // SYNC: active video but no scan slots, client served every cycle.
        ack_cnt = 0;
        for (int x = 302; x < 310; x++) step(x, 100);
        check("sync_acks", ack_cnt, 8);
        check("sync_pixde", pix_de, 0);
        nx_req = 1'b0;
        for (int x = 310; x < 800; x++) step(x, 100);
        short_lines(101, 524);

        // Frame 1: lock at (0,0); first pixel_de two cycles after the next one.
        for (int x = 0; x < 800; x++) begin
            step(x, 0);
            if (x == 2) check("lock_pixde_x2", pix_de, 0);
            if (x == 3) check("lock_pixde_x3", pix_de, 1);
        end
        full_line(1);
        for (int x = 0; x < 800; x++) begin
            step(x, 2);
            if (x == 2) check("pix_aa0", pix_out, 8'hAA);
            if (x == 3) check("pix_aa1", pix_out, 8'hAA);
            if (x == 4) check("pix_bb0", pix_out, 8'hBB);
            if (x == 5) begin check("pix_bb1", pix_out, 8'hBB); check("pix_de_act", pix_de, 1); end
            if (x == 8) check("addr_sy2", mem_addr, 162);
            if (x == 642) begin check("pix_hblank", pix_out, 0); check("pixde_hblank", pix_de, 0); end
        end
        for (int x = 0; x < 800; x++) begin
            if (x == 8) begin nx_req = 1'b1; nx_we = 1'b1; nx_addr = 16'd20000; nx_wdata = 16'h5A5A; end
            if (x == 700) begin nx_req = 1'b1; nx_we = 1'b0; nx_addr = 16'd5; end
            if (x == 701) nx_addr = 16'd6;
            if (x == 702) nx_req = 1'b0;
            step(x, 3);
            if (x == 8) begin check("addr_sy3", mem_addr, 162); check("cont_no_ack", cl_ack, 0); end
            if (x == 9) begin check("cont_ack", cl_ack, 1); nx_req = 1'b0; nx_we = 1'b0; end
            if (x == 700) begin check("rd0_ack", cl_ack, 1); check("rd0_pre", cl_rvalid, 0); end
            if (x == 701) begin check("rd1_ack", cl_ack, 1); check("rd0_valid", cl_rvalid, 1); check("rd0_data", cl_rdata, 5); end
            if (x == 702) begin check("rd1_valid", cl_rvalid, 1); check("rd1_data", cl_rdata, 6); end
            if (x == 703) begin check("rd_done", cl_rvalid, 0); check("rd_hold", cl_rdata, 6); end
        end
        check("cont_writes", wr_cnt, 1);
        check("cont_data", ram[20000], 16'h5A5A);
        short_lines(4, 478);
        for (int x = 0; x < 800; x++) begin
            step(x, 479);
            if (x == 636) check("addr_last", mem_addr, 38399);
        end
        short_lines(480, 524);

        // Frame 2: client saturating; addresses restart at 0.
        ack_cnt = 0;
        nx_req = 1'b1; nx_we = 1'b0; nx_addr = 16'd7;
        for (int x = 0; x < 800; x++) begin
            step(x, 0);
            if (x == 0) begin check("wrap_addr", mem_addr, 0); check("wrap_ack", cl_ack, 0); end
        end
        full_line(1);
        full_line(2);
        full_line(3);
        short_lines(4, 478);
        full_line(479);
        full_line(480);
        short_lines(481, 524);
        // 5 active lines x 640 + 1 blank line x 800 + 519 compressed cycles.
        check("sat_acks", ack_cnt, 4519);
        nx_req = 1'b0;

        // Frame 3: reset mid-frame at (300,100), client still served in SYNC.
        short_lines(0, 99);
        for (int x = 0; x < 300; x++) step(x, 100);
        nx_rst = 1'b1; nx_req = 1'b1; nx_addr = 16'd5;
        step(300, 100);
        step(301, 100);
        check_all_zero("midrst");
        nx_rst = 1'b0;
        ack_cnt = 0;
        for (int x = 302; x < 800; x++) step(x, 100);
        check("midrst_sync_acks", ack_cnt, 498);
        nx_req = 1'b0;
        short_lines(101, 524);

        // Frame 4: scanout resumes after the next (0,0).
        for (int x = 0; x < 800; x++) begin
            step(x, 0);
            if (x == 2) check("relock_pixde_x2", pix_de, 0);
            if (x == 3) check("relock_pixde_x3", pix_de, 1);
        end
        full_line(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
